// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a fixed 13-entry melody table and presents
// one half-period count per note to the downstream square-wave generator.
// Note and gap durations are counted in ticks of TICK_DIV clock cycles.
// All outputs are registered from the next-state decode, so they line up
// with the state register cycle for cycle.
module melody_sequencer #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 8,
    parameter int HP_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            loop_en,
    output logic [HP_W-1:0] half_period,
    output logic            gate,
    output logic            note_strobe,
    output logic [3:0]      note_idx,
    output logic            busy,
    output logic            done
);

    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Melody table: note code per entry.
    function automatic logic [2:0] code_of(input logic [3:0] idx);
        case (idx)
            4'd0:    code_of = 3'd4;
            4'd1:    code_of = 3'd2;
            4'd2:    code_of = 3'd5;
            4'd3:    code_of = 3'd2;
            4'd4:    code_of = 3'd3;
            4'd5:    code_of = 3'd4;
            4'd6:    code_of = 3'd2;
            4'd7:    code_of = 3'd6;
            4'd8:    code_of = 3'd5;
            4'd9:    code_of = 3'd4;
            4'd10:   code_of = 3'd3;
            4'd11:   code_of = 3'd2;
            4'd12:   code_of = 3'd1;
            default: code_of = 3'd0;
        endcase
    endfunction

    // Melody table: duration in ticks per entry (final note is held longer).
    function automatic logic [7:0] dur_of(input logic [3:0] idx);
        case (idx)
            4'd12:   dur_of = 8'd200;
            default: dur_of = 8'd50;
        endcase
    endfunction

    // Note code to speaker half-period in clock cycles; code 0 is a rest.
    function automatic logic [HP_W-1:0] hp_of(input logic [2:0] code);
        case (code)
            3'd1:    hp_of = HP_W'(14'd8513);
            3'd2:    hp_of = HP_W'(14'd7584);
            3'd3:    hp_of = HP_W'(14'd6757);
            3'd4:    hp_of = HP_W'(14'd6378);
            3'd5:    hp_of = HP_W'(14'd5682);
            3'd6:    hp_of = HP_W'(14'd5062);
            default: hp_of = HP_W'(14'd0);
        endcase
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [3:0]      next_idx_s;
    logic            load_s;
    logic [TW-1:0]   tick_cnt_r;
    logic [7:0]      dur_cnt_r;
    logic            last_tick_s;
    logic            note_end_s;
    logic            gap_end_s;

    logic [HP_W-1:0] half_period_s;
    logic            gate_s;
    logic            busy_s;
    logic            done_s;

    assign last_tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign note_end_s  = last_tick_s && (dur_cnt_r == (dur_of(note_idx) - 8'd1));
    assign gap_end_s   = last_tick_s && (dur_cnt_r == 8'(GAP_TICKS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, next-entry and load decode; stop overrides everything.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = note_idx;
        load_s       = 1'b0;
        if (stop) begin
            next_state_s = S_IDLE;
            next_idx_s   = 4'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    next_idx_s = 4'd0;
                    if (start) begin
                        next_state_s = S_NOTE;
                        load_s       = 1'b1;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                S_NOTE: begin
                    if (note_end_s) begin
                        next_state_s = S_GAP;
                    end else begin
                        next_state_s = S_NOTE;
                    end
                end
                S_GAP: begin
                    if (!gap_end_s) begin
                        next_state_s = S_GAP;
                    end else if (note_idx < 4'd12) begin
                        next_state_s = S_NOTE;
                        next_idx_s   = note_idx + 4'd1;
                        load_s       = 1'b1;
                    end else if (loop_en) begin
                        next_state_s = S_NOTE;
                        next_idx_s   = 4'd0;
                        load_s       = 1'b1;
                    end else begin
                        next_state_s = S_DONE;
                        next_idx_s   = 4'd0;
                    end
                end
                S_DONE: begin
                    next_state_s = S_IDLE;
                    next_idx_s   = 4'd0;
                end
                default: begin
                    next_state_s = S_IDLE;
                    next_idx_s   = 4'd0;
                end
            endcase
        end
    end

    // Tick and duration counters, cleared whenever a note or gap begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
            dur_cnt_r  <= 8'd0;
        end else if ((next_state_s != state_r) || load_s) begin
            tick_cnt_r <= '0;
            dur_cnt_r  <= 8'd0;
        end else if (last_tick_s) begin
            tick_cnt_r <= '0;
            dur_cnt_r  <= dur_cnt_r + 8'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Output decode from the next state so registered outputs match the state.
    always_comb begin
        half_period_s = half_period;
        gate_s        = 1'b0;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        case (next_state_s)
            S_IDLE: begin
                half_period_s = '0;
            end
            S_NOTE: begin
                if (load_s) begin
                    half_period_s = hp_of(code_of(next_idx_s));
                end else begin
                    half_period_s = half_period;
                end
                gate_s = (code_of(next_idx_s) != 3'd0);
                busy_s = 1'b1;
            end
            S_GAP: begin
                busy_s = 1'b1;
            end
            S_DONE: begin
                half_period_s = '0;
                done_s        = 1'b1;
            end
            default: begin
                half_period_s = '0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_period <= '0;
            gate        <= 1'b0;
            note_strobe <= 1'b0;
            note_idx    <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            half_period <= half_period_s;
            gate        <= gate_s;
            note_strobe <= load_s;
            note_idx    <= next_idx_s;
            busy        <= busy_s;
            done        <= done_s;
        end
    end

endmodule
